// File: rtl/msg_pkg.sv
// ----------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the message path: the defaults that msg_controller
// and msg_stream_arbiter agree on, the arbiter state encoding, and the
// bytes-to-beats derivation of the message limit.
// ----------------------------------------------------------------------------
package msg_pkg;

    // Arbiter states: waiting for a requester, forwarding a packet, or
    // discarding the tail of an over-long packet.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int MSG_DATA_BYTES    = 8;
    localparam int MSG_TKEEP_WIDTH   = MSG_DATA_BYTES;
    localparam int MSG_MAX_MSG_BYTES = 32;

    // Message limit expressed in beats. The byte limit must be a whole
    // number of beats and at least one beat.
    function automatic int calc_max_beats(input int msg_bytes, input int data_bytes);
        return msg_bytes / data_bytes;
    endfunction

    localparam int MSG_MAX_BEATS = calc_max_beats(MSG_MAX_MSG_BYTES, MSG_DATA_BYTES);

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// the index just after last_winner (wrapping) and returns the first set bit.
//
// Ports:
//   req          in   N        request vector
//   last_winner  in   IW       index granted most recently
//   winner       out  IW       selected index (0 when nothing requests)
//   any_req      out  1        at least one request bit is set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_winner,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // Offset 1..N from the previous winner; offset N is the previous
        // winner itself, so it only wins when nobody else asks.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_winner) + i) % N;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
        any_req = found;
    end

endmodule

// File: rtl/msg_stream_arbiter.sv
// ----------------------------------------------------------------------------
// msg_stream_arbiter
// Packet-level round-robin arbiter in front of msg_controller. A source keeps
// the grant from its first beat to its tlast beat. Packets longer than
// MAX_MSG_BYTES are cut at the limit: the limit beat leaves with tlast and
// tuser forced high, overflow pulses, and the rest of the packet is drained.
// The data path is a pure combinational mux; only control state is stored.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   src_tvalid/tready/tlast/tuser [NUM_SRC]   per-source stream control
//   src_tkeep  [NUM_SRC*TKEEP_WIDTH]          source k in slice k
//   src_tdata  [NUM_SRC*8*DATA_BYTES]         source k in slice k
//   m_tvalid/tready/tlast/tuser/tkeep/tdata   merged stream to msg_controller
//   grant_id       current or most recent granted source
//   grant_active   high while a packet is being forwarded or drained
//   overflow       one-cycle pulse after a truncated beat is accepted
// ----------------------------------------------------------------------------
module msg_stream_arbiter
    import msg_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int DATA_BYTES    = MSG_DATA_BYTES,
    parameter int TKEEP_WIDTH   = MSG_TKEEP_WIDTH,
    parameter int MAX_MSG_BYTES = MSG_MAX_MSG_BYTES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_tvalid,
    output logic [NUM_SRC-1:0]              src_tready,
    input  logic [NUM_SRC-1:0]              src_tlast,
    input  logic [NUM_SRC-1:0]              src_tuser,
    input  logic [NUM_SRC*TKEEP_WIDTH-1:0]  src_tkeep,
    input  logic [NUM_SRC*8*DATA_BYTES-1:0] src_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            m_tuser,
    output logic [TKEEP_WIDTH-1:0]          m_tkeep,
    output logic [8*DATA_BYTES-1:0]         m_tdata,
    output logic [$clog2(NUM_SRC)-1:0]      grant_id,
    output logic                            grant_active,
    output logic                            overflow
);

    localparam int IW        = $clog2(NUM_SRC);
    localparam int DW        = 8 * DATA_BYTES;
    localparam int MAX_BEATS = calc_max_beats(MAX_MSG_BYTES, DATA_BYTES);
    localparam int CW        = $clog2(MAX_BEATS + 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] grant_nxt;
    logic [IW-1:0] last_winner, last_winner_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          overflow_nxt;

    logic [IW-1:0] pick;
    logic          any_req;

    rr_pick #(.N(NUM_SRC), .IW(IW)) u_rr_pick (
        .req         (src_tvalid),
        .last_winner (last_winner),
        .winner      (pick),
        .any_req     (any_req)
    );

    // Granted source's signals.
    logic          sel_tvalid, sel_tlast, sel_tuser;
    logic [TKEEP_WIDTH-1:0] sel_tkeep;
    logic [DW-1:0] sel_tdata;

    assign sel_tvalid = src_tvalid[grant_id];
    assign sel_tlast  = src_tlast[grant_id];
    assign sel_tuser  = src_tuser[grant_id];
    assign sel_tkeep  = src_tkeep[int'(grant_id)*TKEEP_WIDTH +: TKEEP_WIDTH];
    assign sel_tdata  = src_tdata[int'(grant_id)*DW +: DW];

    // beat_cnt counts beats already accepted, so the beat on the wire is the
    // last allowed one when beat_cnt == MAX_BEATS-1.
    logic at_limit, trunc, pass_hs;
    assign at_limit = (beat_cnt == CW'(MAX_BEATS - 1));
    assign trunc    = at_limit && !sel_tlast;
    assign pass_hs  = (state == PASS) && sel_tvalid && m_tready;

    assign grant_active = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_winner <= IW'(NUM_SRC - 1);
            beat_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_id    <= grant_nxt;
            last_winner <= last_winner_nxt;
            beat_cnt    <= beat_cnt_nxt;
            overflow    <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant_id;
        last_winner_nxt = last_winner;
        beat_cnt_nxt    = beat_cnt;
        overflow_nxt    = 1'b0;
        m_tvalid        = 1'b0;
        m_tlast         = 1'b0;
        m_tuser         = 1'b0;
        m_tkeep         = '0;
        m_tdata         = '0;
        src_tready      = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = PASS;
                end
            end

            PASS: begin
                m_tvalid             = sel_tvalid;
                m_tdata              = sel_tdata;
                m_tkeep              = sel_tkeep;
                m_tlast              = sel_tlast | trunc;
                m_tuser              = sel_tuser | trunc;
                src_tready[grant_id] = m_tready;
                if (pass_hs) begin
                    if (beat_cnt != CW'(MAX_BEATS))
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    if (sel_tlast) begin
                        last_winner_nxt = grant_id;
                        state_nxt       = IDLE;
                    end else if (at_limit) begin
                        overflow_nxt = 1'b1;
                        state_nxt    = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Tail beats are accepted and thrown away.
                src_tready[grant_id] = 1'b1;
                if (sel_tvalid && sel_tlast) begin
                    last_winner_nxt = grant_id;
                    state_nxt       = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_msg_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_msg_stream_arbiter
// Directed stimulus with a scoreboard: pushing a packet into a source model
// also queues the beats the arbiter should emit; a negedge monitor pops and
// compares every output handshake, and checks the overflow pulse timing and
// that only the granted source ever sees tready.
// ----------------------------------------------------------------------------
module tb_msg_stream_arbiter;

    localparam int NS = 4;
    localparam int DB = 8;
    localparam int KW = 8;
    localparam int DW = 8 * DB;
    localparam int MB = 4;      // 32 bytes / 8 bytes per beat
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NS-1:0]     src_tvalid, src_tready, src_tlast, src_tuser;
    logic [NS*KW-1:0]  src_tkeep;
    logic [NS*DW-1:0]  src_tdata;
    logic              m_tvalid, m_tready, m_tlast, m_tuser;
    logic [KW-1:0]     m_tkeep;
    logic [DW-1:0]     m_tdata;
    logic [1:0]        grant_id;
    logic              grant_active, overflow;

    always #5 clk = ~clk;

    msg_stream_arbiter #(
        .NUM_SRC(NS), .DATA_BYTES(DB), .TKEEP_WIDTH(KW), .MAX_MSG_BYTES(32)
    ) dut (
        .clk(clk), .rst(rst),
        .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tlast(src_tlast),
        .src_tuser(src_tuser), .src_tkeep(src_tkeep), .src_tdata(src_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tkeep(m_tkeep), .m_tdata(m_tdata),
        .grant_id(grant_id), .grant_active(grant_active), .overflow(overflow)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct packed {
        logic [1:0]    gid;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
        logic          trunc;
    } exp_t;

    beat_t         smem [NS][DEPTH];
    int            wr [NS];
    int            rd [NS];
    exp_t          exp_q [$];
    logic [NS-1:0] hs_src;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit src_pending();
        bit p = 1'b0;
        for (int k = 0; k < NS; k++) if (rd[k] != wr[k]) p = 1'b1;
        return p;
    endfunction

    task automatic drive_srcs();
        for (int k = 0; k < NS; k++) begin
            if (rd[k] < wr[k]) begin
                src_tvalid[k]             = 1'b1;
                src_tlast[k]              = smem[k][rd[k]].last;
                src_tuser[k]              = smem[k][rd[k]].user;
                src_tkeep[k*KW +: KW]     = smem[k][rd[k]].keep;
                src_tdata[k*DW +: DW]     = smem[k][rd[k]].data;
            end else begin
                src_tvalid[k]             = 1'b0;
                src_tlast[k]              = 1'b0;
                src_tuser[k]              = 1'b0;
                src_tkeep[k*KW +: KW]     = '0;
                src_tdata[k*DW +: DW]     = '0;
            end
        end
    endtask

    // Advance one cycle: retire beats the sources handed over, present next.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++)
            if (hs_src[k] === 1'b1 && rd[k] < wr[k]) rd[k]++;
        drive_srcs();
    endtask

    // Queue an n-beat packet on a source; beat i carries byte base+0x11*i.
    // Expected output: first MB beats, the MB-th forced last/user if no tlast.
    task automatic push_pkt(input int src, input int n, input logic [7:0] base, input bit ulast);
        beat_t      b;
        exp_t       e;
        logic [7:0] byt;
        for (int i = 0; i < n; i++) begin
            byt    = 8'(int'(base) + 17 * i);
            b.data = {8{byt}};
            b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
            b.last = (i == n - 1);
            b.user = (i == n - 1) && ulast;
            smem[src][wr[src]] = b;
            wr[src]++;
            if (i < MB) begin
                e.gid   = 2'(src);
                e.data  = b.data;
                e.keep  = b.keep;
                e.trunc = (i == MB - 1) && !b.last;
                e.last  = b.last | e.trunc;
                e.user  = b.user | e.trunc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done(input string name, input bit toggle);
        int n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < 300) begin
            if (toggle) m_tready = ~m_tready;
            tick();
            n++;
        end
        m_tready = 1'b1;
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
        end
        chk({name, "_idle"}, 128'(grant_active), 128'(0));
    endtask

    task automatic wait_src(input int src, input int cnt);
        int n = 0;
        while (rd[src] < cnt && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_src%0d: got %0d beats taken expected %0d", src, rd[src], cnt);
        end
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        logic ovf_exp;
        exp_t e;
        ovf_exp = 1'b0;
        forever begin
            @(negedge clk);
            hs_src = src_tvalid & src_tready;
            if (!rst) begin
                ovf_exp = 1'b0;
            end else begin
                checks++;
                if (overflow !== ovf_exp) begin
                    errors++;
                    $display("FAIL overflow: got %b expected %b", overflow, ovf_exp);
                end
                ovf_exp = 1'b0;
                if (grant_active) begin
                    checks++;
                    if ((src_tready & ~(NS'(1) << grant_id)) != '0) begin
                        errors++;
                        $display("FAIL tready_excl: got %b expected only bit %0d", src_tready, grant_id);
                    end
                end
                if (m_tvalid && m_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got data=%h expected no beat", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({grant_id, m_tdata, m_tkeep, m_tlast, m_tuser} !==
                            {e.gid, e.data, e.keep, e.last, e.user}) begin
                            errors++;
                            $display("FAIL beat: got gid=%0d data=%h keep=%h last=%b user=%b expected gid=%0d data=%h keep=%h last=%b user=%b",
                                     grant_id, m_tdata, m_tkeep, m_tlast, m_tuser,
                                     e.gid, e.data, e.keep, e.last, e.user);
                        end
                        ovf_exp = e.trunc;
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NS; k++) begin
            wr[k] = 0;
            rd[k] = 0;
        end
        m_tready = 1'b0;
        drive_srcs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 128'({m_tvalid, m_tlast, m_tuser, overflow, grant_active}), 128'(0));
        chk("rst_tready", 128'(src_tready), 128'(0));
        chk("rst_gid", 128'(grant_id), 128'(0));
        rst      = 1'b1;
        m_tready = 1'b1;
        tick();
        chk("idle_tvalid", 128'(m_tvalid), 128'(0));

        // Fairness: 0 and 2 both keep requesting -> 0,2,0,2; one-cycle arbitration
        push_pkt(0, 2, 8'h01, 1'b0);
        push_pkt(2, 2, 8'h21, 1'b0);
        push_pkt(0, 2, 8'h41, 1'b0);
        push_pkt(2, 2, 8'h61, 1'b0);
        tick();
        @(negedge clk);
        chk("arb_cycle_tvalid", 128'(m_tvalid), 128'(0));
        tick();
        chk("first_beat_tvalid", 128'(m_tvalid), 128'(1));
        chk("first_beat_gid", 128'(grant_id), 128'(0));
        wait_done("fair", 1'b0);

        // Lock-in: source 0 shows up during source 1's second beat
        push_pkt(1, 3, 8'h81, 1'b0);
        wait_src(1, 1);
        push_pkt(0, 2, 8'hA1, 1'b0);
        wait_done("lockin", 1'b0);

        // Backpressure: 0x11,0x22,0x33,0x44 with m_tready toggling
        push_pkt(2, 4, 8'h11, 1'b0);
        wait_done("bp", 1'b1);

        // Truncation: 6-beat packet from source 3, then 0 and 2 compete
        push_pkt(3, 6, 8'h13, 1'b0);
        wait_src(3, 1);
        push_pkt(0, 1, 8'hC0, 1'b0);
        push_pkt(2, 2, 8'hD0, 1'b0);
        wait_done("trunc", 1'b0);

        // Exact fit: tlast on beat MB, tuser passed through unchanged
        push_pkt(0, 4, 8'h05, 1'b0);
        push_pkt(0, 4, 8'h09, 1'b1);
        wait_done("exact", 1'b0);

        // Reset mid-packet, then 0 must win over 1
        push_pkt(1, 3, 8'h71, 1'b0);
        wait_src(1, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_ctrl", 128'({m_tvalid, m_tlast, m_tuser, grant_active}), 128'(0));
        chk("arst_tready", 128'(src_tready), 128'(0));
        chk("arst_data", 128'({m_tdata, m_tkeep}), 128'(0));
        chk("arst_gid", 128'(grant_id), 128'(0));
        exp_q.delete();
        for (int k = 0; k < NS; k++) rd[k] = wr[k];
        drive_srcs();
        tick();
        tick();
        rst = 1'b1;
        push_pkt(0, 2, 8'hF1, 1'b0);
        push_pkt(1, 2, 8'hE1, 1'b0);
        tick();
        @(negedge clk);
        chk("post_rst_arb_tvalid", 128'(m_tvalid), 128'(0));
        tick();
        chk("post_rst_gid", 128'(grant_id), 128'(0));
        chk("post_rst_tvalid", 128'(m_tvalid), 128'(1));
        wait_done("post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_stream_arbiter.md
Name: msg_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single message-controller input stream between NUM_SRC AXI-stream requesters.
- Holds a grant from the first beat to the tlast beat of a packet.
- Enforces the MAX_MSG_BYTES message limit: an over-long packet is truncated, marked as an error (tlast+tuser), and the remainder is drained.
- Sits directly upstream of msg_controller; its m_* outputs drive that block's s_* inputs.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_BYTES, 8, bytes per beat.
- TKEEP_WIDTH, 8, tkeep width; equals DATA_BYTES.
- MAX_MSG_BYTES, 32, maximum message size; MAX_BEATS = MAX_MSG_BYTES/DATA_BYTES (localparam, must be an integer ≥1).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- src_tvalid  in  NUM_SRC  per-source valid.
- src_tready  out  NUM_SRC  per-source ready.
- src_tlast  in  NUM_SRC  per-source last.
- src_tuser  in  NUM_SRC  per-source error flag.
- src_tkeep  in  NUM_SRC*TKEEP_WIDTH  packed per source; source k occupies slice k.
- src_tdata  in  NUM_SRC*8*DATA_BYTES  packed per source; source k occupies slice k.
- m_tvalid  out  1  selected valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  selected last, or forced on truncation.
- m_tuser  out  1  selected user, or forced on truncation.
- m_tkeep  out  TKEEP_WIDTH  selected keep.
- m_tdata  out  8*DATA_BYTES  selected data.
- grant_id  out  $clog2(NUM_SRC)  current or last granted source.
- grant_active  out  1  high in PASS and DRAIN.
- overflow  out  1  one-cycle pulse on a truncation.

Behaviour:
- Reset values: state=IDLE, grant_id=0, last_winner=NUM_SRC-1 (source 0 has first priority), beat_cnt=0, overflow=0. All m_* outputs and src_tready are 0 during and after reset.
- Reset asserted mid-packet aborts the packet immediately. No tlast is emitted.
- States:
  - IDLE: m_tvalid=0, src_tready=0. If any src_tvalid, pick the first requester after last_winner (cyclic). Register it into grant_id, clear beat_cnt, go to PASS. Arbitration costs exactly one cycle: the first beat is forwarded on the cycle after a request is seen in IDLE.
  - PASS: combinational mux. m_tvalid=src_tvalid[g], src_tready[g]=m_tready, all other src_tready=0. m_tdata, m_tkeep, m_tlast and m_tuser come from source g. A handshake is m_tvalid&&m_tready; each handshake increments beat_cnt.
    - Handshake with src_tlast → IDLE, last_winner=g.
    - Handshake on beat number MAX_BEATS with src_tlast=0 → force m_tlast=1 and m_tuser=1 on that beat, pulse overflow the next cycle, go to DRAIN.
    - Beat MAX_BEATS that already carries tlast ends normally: no overflow, no forcing.
    - Source dropping tvalid mid-packet: m_tvalid=0, grant held, no timeout.
  - DRAIN: m_tvalid=0. src_tready[g]=1; beats are discarded. Handshake with src_tlast → IDLE, last_winner=g. Other sources stay stalled.
- The grant never changes mid-packet, even if other sources request.
- Single-beat packets: PASS lasts one handshake, then IDLE.
- beat_cnt width is $clog2(MAX_BEATS+1) and saturates; it never wraps.
- grant_id holds its value in IDLE until the next grant.
- No payload registers; the data path is purely combinational in PASS.

Decomposition:
- Package msg_pkg holds:
  - the typedef enum arb_state_t {IDLE, PASS, DRAIN};
  - the MAX_BEATS derivation;
  - the shared MAX_MSG_BYTES, DATA_BYTES and TKEEP_WIDTH defaults for msg_controller and this block.
- Sub-module rr_pick (combinational): inputs are the req vector and last_winner; outputs are the winner index and any_req. It is reusable by later schedulers.

Test Plan:
- Fairness: sources 0 and 2 request continuously with 2-beat packets, m_tready=1 → grant order 0, 2, 0, 2. Each packet is preceded by one idle cycle. src_tready is never high for a non-granted source.
- Lock-in: source 1 sends a 3-beat packet; source 0 raises tvalid at beat 2 → beats 2 and 3 still come from source 1. Source 0 is granted only after source 1's tlast.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat packet with data 0x11..,0x22..,0x33..,0x44.. → the output data order is preserved, no beat is duplicated, and beat_cnt ends at 4.
- Truncation: MAX_BEATS=4, source 3 sends 6 beats → beat 4 is output with m_tlast=1 and m_tuser=1. overflow pulses for one cycle. Beats 5 and 6 get src_tready=1 while m_tvalid=0. The next grant goes to the next source after 3.
- Exact fit: MAX_BEATS=4, a 4-beat packet with tlast on beat 4 → m_tuser follows the source, overflow stays 0.
- Reset mid-PASS: rst low during beat 2 → all outputs go to 0 asynchronously. After release, source 0 wins when sources 0 and 1 both request.
